// File: rtl/vga_fetch_pkg.sv
// Shared types and widths for the VGA line fetcher.
//   fetchState_t : fetch controller states
//   ADDR_W       : SDRAM word-address width
//   DATA_W       : SDRAM / pixel word width
package vga_fetch_pkg;
   localparam int ADDR_W = 21;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetchState_t;
endpackage

// File: rtl/vga_fetch_fifo.sv
// Show-ahead pixel FIFO with occupancy count and synchronous clear.
//   clk, reset      : clock, async active-high reset
//   clear           : synchronous flush (wins over push/pop)
//   push, pushData  : write port; push while full is dropped
//   pop             : consume head word; ignored while empty
//   headData        : head word; holds the last popped word while empty
//   empty, count    : status
module vga_fetch_fifo
   import vga_fetch_pkg::*;
#(
   parameter int DEPTH = 512
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      push,
   input  logic [DATA_W-1:0]         pushData,
   input  logic                      pop,
   output logic [DATA_W-1:0]         headData,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wrPtr, rdPtr;
   logic [DATA_W-1:0] lastData;
   logic              doPush, doPop;

   assign empty  = (count == '0);
   assign doPop  = pop && !empty;
   assign doPush = push && (count != CW'(DEPTH));

   always_ff @(posedge clk)
      if (doPush) mem[wrPtr] <= pushData;

   // lastData keeps pixData stable once the FIFO runs dry (also across clear)
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         lastData <= '0;
      end else if (clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop) begin
            rdPtr    <= rdPtr + PTR_W'(1);
            lastData <= mem[rdPtr];
         end
         count <= count + CW'(doPush) - CW'(doPop);
      end

   assign headData = empty ? lastData : mem[rdPtr];
endmodule

// File: rtl/vga_line_fetcher.sv
// Framebuffer scan-out controller: turns per-line requests into SDRAM burst
// reads, keeps up to MAX_OUTSTANDING reads in flight, and only issues a read
// when the pixel FIFO is guaranteed to have room for its data.
//   clk, reset                         : clock, async active-high reset
//   frameStart, baseAddress            : frame resync, new base word address
//   lineReq                            : fetch next line
//   videoRead/Address/WaitRequest      : arbiter request port
//   videoReadValid, videoDataOut       : arbiter return port
//   pixRead, pixData, pixEmpty         : pixel-side FIFO port
//   underrun, underrunCount            : stats, live only with VGA_FETCH_STATS_EN
module vga_line_fetcher
   import vga_fetch_pkg::*;
#(
   parameter int WORDS_PER_LINE  = 160,
   parameter int LINES_PER_FRAME = 480,
   parameter int FIFO_DEPTH      = 512,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frameStart,
   input  logic              lineReq,
   input  logic [ADDR_W-1:0] baseAddress,
   output logic              videoRead,
   output logic [ADDR_W-1:0] videoAddress,
   input  logic              videoWaitRequest,
   input  logic              videoReadValid,
   input  logic [DATA_W-1:0] videoDataOut,
   input  logic              pixRead,
   output logic [DATA_W-1:0] pixData,
   output logic              pixEmpty,
   output logic              underrun,
   output logic [15:0]       underrunCount
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int CRED_W = CNT_W + 1;
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int WORD_W = $clog2(WORDS_PER_LINE);
   localparam int LINE_W = $clog2(LINES_PER_FRAME + 1);

   fetchState_t       state, nextState;
   logic [OUT_W-1:0]  outstanding;
   logic [WORD_W-1:0] wordCount;
   logic [LINE_W-1:0] lineCount;
   logic              pendingLine;
   logic              pushVld;
   logic [DATA_W-1:0] pushData;
   logic [CNT_W-1:0]  fifoCount;
   logic              accept, retire, keepData, lastWord, credit, moreLines, goFlush, fifoClear;

   assign accept    = videoRead && !videoWaitRequest;
   assign retire    = videoReadValid && (outstanding != '0);
   assign keepData  = retire && (state != FLUSH) && !frameStart;
   assign lastWord  = (wordCount == WORD_W'(WORDS_PER_LINE - 1));
   assign moreLines = (pendingLine || lineReq) && (lineCount < LINE_W'(LINES_PER_FRAME - 1));
   assign goFlush   = (outstanding != '0) || (state == FETCH);

   // The word registered in pushVld is in neither the FIFO nor the
   // outstanding count yet, so it is charged explicitly. Credit can only
   // improve while a request waits, so videoRead never drops before accept.
   assign credit = (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                   ((CRED_W'(fifoCount) + CRED_W'(outstanding) + CRED_W'(pushVld))
                    < CRED_W'(FIFO_DEPTH));

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= nextState;

   // next state
   always_comb begin
      nextState = state;
      if (frameStart)
         nextState = goFlush ? FLUSH : IDLE;
      else
         case (state)
            IDLE:    if (lineReq && (lineCount < LINE_W'(LINES_PER_FRAME))) nextState = FETCH;
            FETCH:   if (accept && lastWord && !moreLines) nextState = IDLE;
            FLUSH:   if (outstanding == '0) nextState = IDLE;
            default: nextState = IDLE;
         endcase
   end

   // outputs
   always_comb begin
      videoRead = (state == FETCH) && credit && !frameStart;
      fifoClear = frameStart ? !goFlush : ((state == FLUSH) && (outstanding == '0));
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         videoAddress <= '0;
         wordCount    <= '0;
         lineCount    <= '0;
         pendingLine  <= 1'b0;
         outstanding  <= '0;
         pushVld      <= 1'b0;
         pushData     <= '0;
      end else begin
         pushVld  <= keepData;
         pushData <= videoDataOut;
         case ({accept, retire})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: ;
         endcase
         if (frameStart) begin
            videoAddress <= baseAddress;
            wordCount    <= '0;
            lineCount    <= '0;
            pendingLine  <= 1'b0;
         end else begin
            if (state == IDLE && nextState == FETCH) wordCount <= '0;
            if (accept) begin
               videoAddress <= videoAddress + ADDR_W'(1);
               if (lastWord) begin
                  wordCount <= '0;
                  lineCount <= lineCount + LINE_W'(1);
               end else
                  wordCount <= wordCount + WORD_W'(1);
            end
            // a line request landing on the last accept is consumed by moreLines
            if (accept && lastWord)            pendingLine <= 1'b0;
            else if (state == FETCH && lineReq) pendingLine <= 1'b1;
         end
      end

   vga_fetch_fifo #(.DEPTH(FIFO_DEPTH)) pixFifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (fifoClear),
      .push     (pushVld),
      .pushData (pushData),
      .pop      (pixRead),
      .headData (pixData),
      .empty    (pixEmpty),
      .count    (fifoCount)
   );

`ifdef VGA_FETCH_STATS_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         underrun      <= 1'b0;
         underrunCount <= '0;
      end else begin
         if (frameStart)               underrun <= 1'b0;
         else if (pixRead && pixEmpty) underrun <= 1'b1;
         if (pixRead && pixEmpty && underrunCount != 16'hFFFF)
            underrunCount <= underrunCount + 16'd1;
      end
`else
   assign underrun      = 1'b0;
   assign underrunCount = '0;
`endif
endmodule

// File: tb/tb_vga_line_fetcher.sv
// Randomized bench for vga_line_fetcher. The bench plays the SDRAM arbiter
// (in-order returns, random latency and stalls) and keeps a transaction-level
// model: words still owed, reads in flight, FIFO contents as a queue.
// Lines per frame is reduced so the per-frame cap is reached quickly.
module tb_vga_line_fetcher;
   localparam int WPL = 160, LPF = 6, DEPTH = 512, MAXO = 8;

   logic        clk = 1'b0, reset, frameStart, lineReq;
   logic [20:0] baseAddress, videoAddress;
   logic        videoRead, videoWaitRequest, videoReadValid, pixRead, pixEmpty, underrun;
   logic [31:0] videoDataOut, pixData;
   logic [15:0] underrunCount;

   vga_line_fetcher #(.WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF),
                      .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset), .frameStart(frameStart), .lineReq(lineReq),
      .baseAddress(baseAddress), .videoRead(videoRead), .videoAddress(videoAddress),
      .videoWaitRequest(videoWaitRequest), .videoReadValid(videoReadValid),
      .videoDataOut(videoDataOut), .pixRead(pixRead), .pixData(pixData),
      .pixEmpty(pixEmpty), .underrun(underrun), .underrunCount(underrunCount)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; bit discard; } ret_t;
   ret_t        retQ[$];     // accepted reads not yet returned, in order
   logic [31:0] fifoQ[$];    // words visible in the pixel FIFO
   logic [31:0] lastPopped, transitData;
   bit          transit, flushing, urFlag;
   int          wordsLeft, linesAcc, urCount, acceptCount, nVec, nErr, a0;
   logic [20:0] expAddr;

   function automatic logic [31:0] memWord(input logic [20:0] a);
      return {a[10:0], a} ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int pFs, input int pLr, input int pWait, input int pRet, input int pPix);
      frameStart       = ($urandom_range(999) < pFs);
      lineReq          = ($urandom_range(99) < pLr);
      baseAddress      = 21'($urandom);
      videoWaitRequest = ($urandom_range(99) < pWait);
      if (retQ.size() > 0) begin
         videoReadValid = ($urandom_range(99) < pRet);
         videoDataOut   = retQ[0].data;
      end else begin
         videoReadValid = ($urandom_range(99) < 3);   // stray valid, must be ignored
         videoDataOut   = $urandom;
      end
      pixRead = !frameStart && !flushing && ($urandom_range(99) < pPix);
   endtask

   // one clock: check outputs against the model, then advance the model
   task automatic step();
      int   infl, wlPre;
      bit   acc, expRd;
      ret_t r;
      @(negedge clk);
      infl  = retQ.size();
      wlPre = wordsLeft;
      expRd = !frameStart && !flushing && wlPre > 0 && infl < MAXO &&
              (fifoQ.size() + int'(transit) + infl) < DEPTH;
      chk("videoRead", 32'(videoRead), 32'(expRd));
      if (videoRead) chk("videoAddress", 32'(videoAddress), 32'(expAddr));
      if (!flushing) begin
         chk("pixEmpty", 32'(pixEmpty), 32'(fifoQ.size() == 0));
         chk("pixData", pixData, (fifoQ.size() > 0) ? fifoQ[0] : lastPopped);
      end
`ifdef VGA_FETCH_STATS_EN
      chk("underrun", 32'(underrun), 32'(urFlag));
      chk("underrunCount", 32'(underrunCount), 32'(urCount));
`else
      chk("underrun", 32'(underrun), 32'd0);
      chk("underrunCount", 32'(underrunCount), 32'd0);
`endif
      acc = videoRead && !videoWaitRequest;
      if (pixRead) begin
         if (fifoQ.size() == 0) begin
            if (urCount < 65535) urCount++;
            urFlag = 1'b1;
         end else
            lastPopped = fifoQ.pop_front();
      end
      if (transit) fifoQ.push_back(transitData);
      transit = 1'b0;
      if (videoReadValid && infl > 0) begin
         r = retQ.pop_front();
         if (!r.discard && !frameStart) begin
            transit     = 1'b1;
            transitData = r.data;
         end
      end
      if (acc) begin
         acceptCount++;
         retQ.push_back('{memWord(expAddr), 1'b0});
         expAddr++;
         wordsLeft--;
      end
      if (frameStart) begin
         expAddr   = baseAddress;
         wordsLeft = 0;
         linesAcc  = 0;
         fifoQ.delete();
         transit   = 1'b0;
         urFlag    = 1'b0;
         foreach (retQ[i]) retQ[i].discard = 1'b1;
         flushing  = (wlPre > 0) || (infl > 0);
      end else begin
         // one line in progress plus at most one queued
         if (lineReq && !flushing && wlPre <= WPL && linesAcc < LPF) begin
            wordsLeft += WPL;
            linesAcc++;
         end
         if (flushing && infl == 0) flushing = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      frameStart = 0; lineReq = 0; videoWaitRequest = 0; videoReadValid = 0; pixRead = 0;
      videoDataOut = '0; baseAddress = '0;
      retQ.delete(); fifoQ.delete();
      transit = 0; flushing = 0; urFlag = 0; urCount = 0;
      lastPopped = '0; wordsLeft = 0; linesAcc = 0; expAddr = '0;
      @(negedge clk);
      chk("rst videoRead", 32'(videoRead), 32'd0);
      chk("rst videoAddress", 32'(videoAddress), 32'd0);
      chk("rst pixEmpty", 32'(pixEmpty), 32'd1);
      chk("rst pixData", pixData, 32'd0);
      chk("rst underrun", 32'(underrun), 32'd0);
      chk("rst underrunCount", 32'(underrunCount), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic runRandom(input int n);
      int pFs, pLr, pWait, pRet, pPix;
      pFs = $urandom_range(0, 4); pLr = $urandom_range(1, 10); pWait = $urandom_range(0, 70);
      pRet = $urandom_range(10, 100); pPix = $urandom_range(0, 90);
      repeat (n) begin
         drive(pFs, pLr, pWait, pRet, pPix);
         step();
      end
   endtask

   initial begin
      nVec = 0; nErr = 0; acceptCount = 0;
      #1 doReset();

      // one full line from a fixed base, prompt returns
      drive(0, 0, 0, 100, 0); frameStart = 1; baseAddress = 21'h001000; step();
      a0 = acceptCount;
      drive(0, 0, 0, 100, 0); lineReq = 1; step();
      repeat (400) begin drive(0, 0, 0, 100, 0); step(); end
      chk("line1Accepts", 32'(acceptCount - a0), 32'd160);

      // returns withheld: in-flight limit, then one return frees one slot
      a0 = acceptCount;
      drive(0, 0, 0, 0, 0); lineReq = 1; step();
      repeat (30) begin drive(0, 0, 0, 0, 0); step(); end
      chk("heldAccepts", 32'(acceptCount - a0), 32'(MAXO));
      a0 = acceptCount;
      drive(0, 0, 0, 0, 0); videoReadValid = 1; videoDataOut = retQ[0].data; step();
      repeat (10) begin drive(0, 0, 0, 0, 0); step(); end
      chk("oneMoreAccept", 32'(acceptCount - a0), 32'd1);

      // finish the line with arbiter stalls
      repeat (500) begin drive(0, 0, 40, 80, 0); step(); end

      // fill the FIFO with no pixel reads, then free exactly one word
      drive(0, 0, 0, 100, 0); frameStart = 1; step();
      repeat (40) begin drive(0, 0, 0, 100, 0); step(); end
      a0 = acceptCount;
      repeat (3000) begin drive(0, 2, 0, 100, 0); step(); end
      chk("fillAccepts", 32'(acceptCount - a0), 32'(DEPTH));
      a0 = acceptCount;
      drive(0, 0, 0, 100, 0); pixRead = 1; step();
      repeat (20) begin drive(0, 0, 0, 100, 0); step(); end
      chk("popOneAccept", 32'(acceptCount - a0), 32'd1);
      repeat (1500) begin drive(0, 0, 0, 100, 80); step(); end

      // frame restart with reads in flight, then fetch from the new base
      drive(0, 0, 0, 100, 0); frameStart = 1; step();
      drive(0, 0, 0, 0, 0); lineReq = 1; step();
      repeat (20) begin drive(0, 0, 0, 0, 0); step(); end
      drive(0, 0, 0, 0, 0); frameStart = 1; step();
      repeat (40) begin drive(0, 0, 0, 50, 0); step(); end
      drive(0, 0, 0, 100, 0); lineReq = 1; step();
      repeat (400) begin drive(0, 0, 10, 100, 50); step(); end

      for (int k = 0; k < 8; k++) runRandom(2500);
      doReset();
      for (int k = 0; k < 2; k++) runRandom(1500);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
